// File: rtl/seq_detector_param_if.sv
// rtl/seq_detector_param_if.sv - stream, config and status bundle for seq_detector_param
interface seq_detector_param_if #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8
);
  logic             din_valid;
  logic             din;
  logic             cfg_load;
  logic [PAT_W-1:0] cfg_pattern;
  logic [PAT_W-1:0] cfg_mask;
  logic             cfg_overlap;
  logic             cnt_clr;
  logic             dout;
  logic [CNT_W-1:0] match_cnt;
  logic             cnt_sat;

  modport master (
    output din_valid, din, cfg_load, cfg_pattern, cfg_mask, cfg_overlap, cnt_clr,
    input  dout, match_cnt, cnt_sat
  );

  modport slave (
    input  din_valid, din, cfg_load, cfg_pattern, cfg_mask, cfg_overlap, cnt_clr,
    output dout, match_cnt, cnt_sat
  );
endinterface

// File: rtl/seq_detector_param.sv
// rtl/seq_detector_param.sv - programmable masked serial pattern detector with match counter
// Define SEQ_DET_REG_OUT_EN to register dout one cycle after the final pattern bit.
module seq_detector_param #(
  parameter int               PAT_W       = 4,
  parameter int               CNT_W       = 8,
  parameter logic [PAT_W-1:0] RST_PATTERN = PAT_W'(4'b1010),
  parameter logic [PAT_W-1:0] RST_MASK    = '1,
  parameter logic             RST_OVERLAP = 1'b1
) (
  input logic                 clk,
  input logic                 rst,
  seq_detector_param_if.slave bus
);
  localparam int FILL_W = $clog2(PAT_W);

  typedef enum logic {S_FILL, S_ARMED} state_t;

  state_t           state_q, state_d;
  logic [PAT_W-2:0] hist_q, hist_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [PAT_W-1:0] mask_q, mask_d;
  logic             ovl_q, ovl_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PAT_W-1:0] cand;
  logic             match;

  // Newest bit sits in the LSB, so the oldest history bit lines up with pattern MSB.
  assign cand  = {hist_q, bus.din};
  assign match = ~rst & bus.din_valid & ~bus.cfg_load & (state_q == S_ARMED) &
                 (((cand ^ pat_q) & mask_q) == '0);

  always_comb begin
    state_d = state_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    pat_d   = pat_q;
    mask_d  = mask_q;
    ovl_d   = ovl_q;
    cnt_d   = cnt_q;

    if (bus.cfg_load) begin
      pat_d   = bus.cfg_pattern;
      mask_d  = bus.cfg_mask;
      ovl_d   = bus.cfg_overlap;
      hist_d  = '0;
      fill_d  = '0;
      state_d = S_FILL;
    end else if (bus.din_valid) begin
      if (match && !ovl_q) begin
        hist_d  = '0;
        fill_d  = '0;
        state_d = S_FILL;
      end else begin
        hist_d = cand[PAT_W-2:0];
        if (state_q == S_FILL) begin
          fill_d = fill_q + FILL_W'(1);
          if (fill_q == FILL_W'(PAT_W-2)) state_d = S_ARMED;
        end
      end
    end

    if (bus.cnt_clr) cnt_d = '0;
    else if (match && !(&cnt_q)) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FILL;
      hist_q  <= '0;
      fill_q  <= '0;
      pat_q   <= RST_PATTERN;
      mask_q  <= RST_MASK;
      ovl_q   <= RST_OVERLAP;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      pat_q   <= pat_d;
      mask_q  <= mask_d;
      ovl_q   <= ovl_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef SEQ_DET_REG_OUT_EN
  logic dout_q, dout_d;

  always_comb begin
    dout_d = match;
  end

  always_ff @(posedge clk) begin
    if (rst) dout_q <= 1'b0;
    else     dout_q <= dout_d;
  end

  assign bus.dout = dout_q;
`else
  assign bus.dout = match;
`endif

  assign bus.match_cnt = cnt_q;
  assign bus.cnt_sat   = &cnt_q;
endmodule
